phy_lane_sched: RTL and testbench

PHY_LANE_SCHED -- requirements
Module: phy_lane_sched

---
 rtl/phy_lane_sched_if.sv | 23 ++
 rtl/phy_lane_sched.sv | 132 +++++++++++++
 tb/tb_phy_lane_sched.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/phy_lane_sched_if.sv
// Requester-side bundle of the lane scheduler: request/data in, grant/data out.
// Scheduler owns the grant side; requesters own req and the candidate bytes.
interface phy_lane_sched_if;
    logic [3:0] req;
    logic [7:0] data_req0;
    logic [7:0] data_req1;
    logic [7:0] data_req2;
    logic [7:0] data_req3;
    logic [3:0] gnt;
    logic [7:0] data_out;
    logic       valid_out;
    logic       idle_out;

    modport master (
        output req, data_req0, data_req1, data_req2, data_req3,
        input  gnt, data_out, valid_out, idle_out
    );

    modport slave (
        input  req, data_req0, data_req1, data_req2, data_req3,
        output gnt, data_out, valid_out, idle_out
    );
endinterface

// File: rtl/phy_lane_sched.sv
// Round-robin lane scheduler gated by a PHY link bring-up FSM; all outputs registered.
// Latency 1 cycle req->gnt; no backpressure, requesters simply hold req until granted.
module phy_lane_sched #(
    parameter logic [7:0] IDLE_SYM = 8'hBC
) (
    input  logic                  clk_f,
    input  logic                  default_values,
    input  logic                  phy_active,
    input  logic [3:0]            init_limit,
    phy_lane_sched_if.slave       lane,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        ST_RESET  = 2'b00,
        ST_INIT   = 2'b01,
        ST_IDLE   = 2'b10,
        ST_ACTIVE = 2'b11
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic [1:0] r_ptr, w_ptr_nxt;
    logic [3:0] r_gnt, w_gnt_nxt;
    logic [7:0] r_data, w_data_nxt;
    logic       r_valid, w_valid_nxt;
    logic       r_idle, w_idle_nxt;

    logic [3:0] w_lim;
    logic [3:0] w_cnt_inc;
    logic [7:0] w_data_req [4];
    logic       w_win_vld;
    logic [1:0] w_win_idx;
    logic [1:0] w_cand;

    assign w_lim     = (init_limit == 4'd0) ? 4'd1 : init_limit;
    assign w_cnt_inc = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;

    assign w_data_req[0] = lane.data_req0;
    assign w_data_req[1] = lane.data_req1;
    assign w_data_req[2] = lane.data_req2;
    assign w_data_req[3] = lane.data_req3;

    // First requester found walking up from the pointer wins.
    always_comb begin
        w_win_vld = 1'b0;
        w_win_idx = 2'd0;
        w_cand    = 2'd0;
        for (int i = 0; i < 4; i++) begin
            w_cand = r_ptr + 2'(i);
            if (!w_win_vld && lane.req[w_cand]) begin
                w_win_vld = 1'b1;
                w_win_idx = w_cand;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_gnt_nxt   = 4'd0;
        w_data_nxt  = IDLE_SYM;
        w_valid_nxt = 1'b0;
        case (r_state)
            ST_RESET: w_state_nxt = ST_INIT;
            ST_INIT: begin
                if (!phy_active) begin
                    w_cnt_nxt = 4'd0;
                end else if (w_cnt_inc >= w_lim) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ST_IDLE: begin
                if (!phy_active) begin
                    w_state_nxt = ST_INIT;
                    w_cnt_nxt   = 4'd0;
                    w_ptr_nxt   = 2'd0;
                end else if (lane.req != 4'd0) begin
                    w_state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                // Link loss outranks both the drop to IDLE and any grant.
                if (!phy_active) begin
                    w_state_nxt = ST_INIT;
                    w_cnt_nxt   = 4'd0;
                    w_ptr_nxt   = 2'd0;
                end else if (!w_win_vld) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gnt_nxt   = 4'b0001 << w_win_idx;
                    w_data_nxt  = w_data_req[w_win_idx];
                    w_valid_nxt = 1'b1;
                    w_ptr_nxt   = w_win_idx + 2'd1;
                end
            end
            default: w_state_nxt = ST_RESET;
        endcase
        w_idle_nxt = (w_state_nxt == ST_IDLE);
    end

    always_ff @(posedge clk_f or negedge default_values) begin
        if (!default_values) begin
            r_state <= ST_RESET;
            r_cnt   <= 4'd0;
            r_ptr   <= 2'd0;
            r_gnt   <= 4'd0;
            r_data  <= IDLE_SYM;
            r_valid <= 1'b0;
            r_idle  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gnt   <= w_gnt_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_idle  <= w_idle_nxt;
        end
    end

    assign state          = r_state;
    assign lane.gnt       = r_gnt;
    assign lane.data_out  = r_data;
    assign lane.valid_out = r_valid;
    assign lane.idle_out  = r_idle;

endmodule

// File: tb/tb_phy_lane_sched.sv
// Randomized and directed bench for phy_lane_sched with a queue-based scoreboard.
module tb_phy_lane_sched;

    logic       clk_f = 1'b0;
    logic       default_values;
    logic       phy_active;
    logic [3:0] init_limit;
    logic [1:0] state;

    always #5 clk_f = ~clk_f;

    phy_lane_sched_if lane ();

    phy_lane_sched #(.IDLE_SYM(8'hBC)) dut (
        .clk_f          (clk_f),
        .default_values (default_values),
        .phy_active     (phy_active),
        .init_limit     (init_limit),
        .lane           (lane),
        .state          (state)
    );

    typedef struct packed {
        logic [1:0] st;
        logic [3:0] gnt;
        logic [7:0] dat;
        logic       vld;
        logic       idl;
    } obs_t;

    obs_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: link phase, run of consecutive link-alive cycles, next requester in line.
    int   m_phase;   // 0 reset, 1 bring-up, 2 idle, 3 active
    int   m_run;
    int   m_next;
    obs_t m_out;

    function automatic logic [7:0] cand_byte(input int c);
        case (c)
            0:       return lane.data_req0;
            1:       return lane.data_req1;
            2:       return lane.data_req2;
            default: return lane.data_req3;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_run   = 0;
        m_next  = 0;
        m_out   = '{st: 2'd0, gnt: 4'd0, dat: 8'hBC, vld: 1'b0, idl: 1'b0};
    endtask

    task automatic model_step();
        int need;
        if (!default_values) begin
            model_reset();
            return;
        end
        need      = (init_limit == 4'd0) ? 1 : int'(init_limit);
        m_out.gnt = 4'd0;
        m_out.dat = 8'hBC;
        m_out.vld = 1'b0;
        if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            m_run = phy_active ? m_run + 1 : 0;
            if (m_run >= need) begin
                m_phase = 2;
                m_run   = 0;
            end
        end else if (!phy_active) begin
            m_phase = 1;
            m_run   = 0;
            m_next  = 0;
        end else if (lane.req == 4'd0) begin
            m_phase = 2;
        end else if (m_phase == 2) begin
            m_phase = 3;
        end else begin
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (m_next + k) % 4;
                if (lane.req[c]) begin
                    m_out.gnt = 4'(1 << c);
                    m_out.dat = cand_byte(c);
                    m_out.vld = 1'b1;
                    m_next    = (c + 1) % 4;
                    break;
                end
            end
        end
        m_out.st  = 2'(m_phase);
        m_out.idl = (m_phase == 2);
    endtask

    // Predict the coming edge, then let it happen; returns 2 time units after the edge.
    task automatic tick();
        model_step();
        exp_q.push_back(m_out);
        @(posedge clk_f);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic set_req(input logic [3:0] r, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
        lane.req       = r;
        lane.data_req0 = b0;
        lane.data_req1 = b1;
        lane.data_req2 = b2;
        lane.data_req3 = b3;
    endtask

    always @(posedge clk_f) begin
        obs_t e, g;
        #1;
        if (exp_q.size() > 0) begin
            e     = exp_q.pop_front();
            g.st  = state;
            g.gnt = lane.gnt;
            g.dat = lane.data_out;
            g.vld = lane.valid_out;
            g.idl = lane.idle_out;
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL edge_%0t got st=%0d gnt=%b dat=%h vld=%b idl=%b want st=%0d gnt=%b dat=%h vld=%b idl=%b",
                         $time, g.st, g.gnt, g.dat, g.vld, g.idl, e.st, e.gnt, e.dat, e.vld, e.idl);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] st_seq[7];
        logic [3:0] g_seq[5];
        logic [7:0] d_seq[5];
        logic       pa_seq[7];

        default_values = 1'b1;
        phy_active     = 1'b1;
        init_limit     = 4'd3;
        set_req(4'd0, 8'h00, 8'h00, 8'h00, 8'h00);
        model_reset();
        #1 default_values = 1'b0;
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_gnt", 32'(lane.gnt), 32'd0);
        chk("rst_data", 32'(lane.data_out), 32'hBC);
        chk("rst_valid_idle", 32'({lane.valid_out, lane.idle_out}), 32'd0);
        tick();
        tick();

        // Link bring-up with limit 3
        default_values = 1'b1;
        st_seq = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0};
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("bringup_st%0d", i), 32'(state), 32'(st_seq[i]));
        end
        chk("bringup_idle", 32'({lane.idle_out, lane.data_out}), 32'h1BC);

        // Glitch during bring-up with limit 4
        phy_active = 1'b0;
        tick();
        init_limit = 4'd4;
        pa_seq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        st_seq = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
        for (int i = 0; i < 7; i++) begin
            phy_active = pa_seq[i];
            tick();
            chk($sformatf("glitch_st%0d", i), 32'(state), 32'(st_seq[i]));
        end

        // Full round-robin
        set_req(4'b1111, 8'h10, 8'h11, 8'h12, 8'h13);
        tick();
        chk("rr_enter", 32'({state, lane.valid_out}), 32'({2'd3, 1'b0}));
        g_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        d_seq = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("rr_gnt%0d", i), 32'({lane.gnt, lane.data_out, lane.valid_out}),
                32'({g_seq[i], d_seq[i], 1'b1}));
        end

        // Sparse requests from pointer 0 (link bounce clears the pointer)
        phy_active = 1'b0;
        tick();
        phy_active = 1'b1;
        init_limit = 4'd1;
        tick();
        set_req(4'b1010, 8'h20, 8'h21, 8'h22, 8'h23);
        tick();
        g_seq = '{4'b0010, 4'b1000, 4'b0010, 4'b0000, 4'b0000};
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("sparse_gnt%0d", i), 32'(lane.gnt), 32'(g_seq[i]));
        end
        lane.req = 4'd0;
        tick();
        chk("sparse_drop", 32'({state, lane.valid_out, lane.idle_out, lane.data_out}),
            32'({2'd2, 1'b0, 1'b1, 8'hBC}));

        // Link loss while active, then pointer restarts at 0
        set_req(4'b0100, 8'h30, 8'h31, 8'h32, 8'h33);
        tick();
        tick();
        chk("loss_pre_gnt", 32'(lane.gnt), 32'b0100);
        phy_active = 1'b0;
        tick();
        chk("loss_state", 32'({state, lane.gnt, lane.valid_out}), 32'({2'd1, 4'd0, 1'b0}));
        phy_active = 1'b1;
        tick();
        lane.req = 4'b1111;
        tick();
        tick();
        chk("loss_regrant", 32'({lane.gnt, lane.data_out}), 32'({4'b0001, 8'h30}));

        // Asynchronous reset between edges while granting
        tick();
        default_values = 1'b0;
        #1;
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_outs", 32'({lane.gnt, lane.data_out, lane.valid_out, lane.idle_out}),
            32'({4'd0, 8'hBC, 1'b0, 1'b0}));
        model_reset();
        tick();
        default_values = 1'b1;
        tick();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            default_values = ($urandom_range(0, 199) != 0);
            phy_active     = ($urandom_range(0, 19) != 0);
            init_limit     = 4'($urandom_range(0, 5));
            set_req(($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15)),
                    8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            tick();
        end

        repeat (2) @(posedge clk_f);
        #2;
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
